config_pipe_core: RTL and testbench
===================================

Name: config_pipe_core

Overview:
- Parametrised successor to the single-purpose dummy core. Holds a bank of NUM_REGS address-decoded config registers with byte-enabled writes and a registered read-back path with valid.
- Carries a 16b data lane and a 1b data lane through a programmable delay line, 0..MAX_DELAY cycles, with an output gate.
- Sits in a tile as a generic core behind the standard config bus.

Parameters:
- DATA_WIDTH, 16, width of the wide data lane.
- CONFIG_ADDR_WIDTH, 8, config address width.
- CONFIG_DATA_WIDTH, 32, config word width. Must be a multiple of 8.
- NUM_REGS, 4, number of config registers. Range 2..2^CONFIG_ADDR_WIDTH.
- MAX_DELAY, 7, maximum programmable lane delay in cycles. Range 1..15.

Ports:
- clk, in, 1: single clock, all state on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- config_config_addr, in, CONFIG_ADDR_WIDTH: register index.
- config_config_data, in, CONFIG_DATA_WIDTH: write data.
- config_byte_en, in, CONFIG_DATA_WIDTH/8: write byte enables.
- config_read, in, 1: read request.
- config_write, in, 1: write request.
- read_config_data, out, CONFIG_DATA_WIDTH: registered read data.
- read_config_valid, out, 1: read data valid pulse.
- data_in_16b, in, DATA_WIDTH: wide lane input.
- data_in_1b, in, 1: bit lane input.
- data_out_16b, out, DATA_WIDTH: delayed, gated wide lane.
- data_out_1b, out, 1: delayed, gated bit lane.

Behaviour:
- Reset (reset low, asynchronous): all config registers, read_config_data, read_config_valid and all delay-line stages clear to 0. With REG0 = 0 and REG1 = 0, both data outputs read 0.
- Write: config_write=1 and addr < NUM_REGS updates byte i of reg[addr] at the next edge, for each byte where config_byte_en[i]=1. Other bytes hold.
- Write to addr >= NUM_REGS is ignored, with no side effects.
- Read: config_read=1 in cycle N gives read_config_valid=1 in cycle N+1 with read_config_data = reg[addr] as sampled in cycle N.
- Read of addr >= NUM_REGS returns 0 with valid=1.
- read_config_valid is low in every cycle not preceded by a read. read_config_data holds its last value when valid is low.
- Read and write in the same cycle, same address: read returns the pre-write value; the write still takes effect.
- REG0[3:0] is DELAY. Effective delay is min(DELAY, MAX_DELAY).
- REG1[0] is OUT_EN. When 0, both data outputs are forced to 0. The gate is combinational, after the delay line.
- Registers 2..NUM_REGS-1 are scratch storage with no side effects.
- Delay line: a shift chain of MAX_DELAY stages per lane, shifting every cycle regardless of config state.
  - Output = stage[d-1] for d>0.
  - Output = input, combinational, for d=0.
- Changing DELAY mid-stream switches the tap on the cycle after the write edge. There is no flush; values already in the chain are emitted per the new tap.
- Mid-operation reset clears the chain. After release, outputs show 0 until new data propagates.

Decomposition:
- Package config_pipe_pkg:
  - register index constants: REG_DELAY=0, REG_CTRL=1.
  - field positions: DELAY_LSB=0, DELAY_W=4, OUT_EN_BIT=0.
  - a byte-merge function.
- Sub-module config_pipe_delay_line, parametrised by WIDTH and MAX_DELAY. Inputs: clk, reset, din, delay select. Output: dout. Instantiated once per lane.
- Config bank and read path stay in the top.

Test Plan:
- Reset and defaults: assert reset low mid-traffic → all outputs 0. After release, data_in_16b=16'hABCD gives data_out_16b=0 because OUT_EN=0.
- Byte-enabled write and read: write addr 2, data 32'h11223344, be=4'b1111. Then write 32'hFFFFFFFF with be=4'b0010. Read addr 2 → one cycle later valid=1 and data 32'h1122FF44. Valid is low in the following cycle.
- Out-of-range addressing (NUM_REGS=4): write addr 8'h05, then read addr 8'h05 → data 0, valid 1. Registers 0..3 are unchanged.
- Read/write collision: reg3=32'h5, then read and write 32'h9 to addr 3 in the same cycle → read returns 32'h5. The next read returns 32'h9.
- Delay programming:
  - With OUT_EN=1 and DELAY=0, drive an incrementing ramp → data_out_16b equals data_in_16b in the same cycle.
  - DELAY=3 → output lags by exactly 3 cycles, and data_out_1b tracks the same lag.
  - DELAY=15 with MAX_DELAY=7 → lag is 7.
- Mid-stream delay change and gating:
  - Change DELAY from 3 to 1 during the ramp → the output jumps to the 1-cycle-lagged value on the cycle after the write.
  - Clear OUT_EN → outputs are 0 in the same cycle the register updates.

Source files
------------

// File: rtl/config_pipe_pkg.sv
// Shared definitions for config_pipe_core.
//   - register indices of the two functional config registers
//   - bit positions of the fields inside those registers
//   - merge_byte: per-byte write-enable merge used by the config bank
package config_pipe_pkg;

  localparam int REG_DELAY  = 0;
  localparam int REG_CTRL   = 1;

  localparam int DELAY_LSB  = 0;
  localparam int DELAY_W    = 4;
  localparam int OUT_EN_BIT = 0;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/config_pipe_core_if.sv
// Config bus between a tile controller (master) and a core (slave).
//   config_config_addr  : register index
//   config_config_data  : write data
//   config_byte_en      : write byte enables
//   config_read         : read request
//   config_write        : write request
//   read_config_data    : registered read data (slave -> master)
//   read_config_valid   : read data valid pulse (slave -> master)
interface config_pipe_core_if #(
  parameter int CONFIG_ADDR_WIDTH = 8,
  parameter int CONFIG_DATA_WIDTH = 32
) ();

  logic [CONFIG_ADDR_WIDTH-1:0]   config_config_addr;
  logic [CONFIG_DATA_WIDTH-1:0]   config_config_data;
  logic [CONFIG_DATA_WIDTH/8-1:0] config_byte_en;
  logic                           config_read;
  logic                           config_write;
  logic [CONFIG_DATA_WIDTH-1:0]   read_config_data;
  logic                           read_config_valid;

  modport master (
    output config_config_addr, config_config_data, config_byte_en,
           config_read, config_write,
    input  read_config_data, read_config_valid
  );

  modport slave (
    input  config_config_addr, config_config_data, config_byte_en,
           config_read, config_write,
    output read_config_data, read_config_valid
  );

endinterface

// File: rtl/config_pipe_delay_line.sv
// Programmable delay line for one data lane.
//   clk, reset (async, active-low) : clock / reset, reset clears every stage
//   din        : lane input
//   delay_sel  : requested delay, saturated to MAX_DELAY
//   dout       : din when delay is 0, otherwise the tapped stage
// The chain shifts every cycle; only the output tap depends on delay_sel,
// so changing the delay re-taps the existing contents without a flush.
module config_pipe_delay_line
  import config_pipe_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_DELAY = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   din,
  input  logic [DELAY_W-1:0] delay_sel,
  output logic [WIDTH-1:0]   dout
);

  logic [WIDTH-1:0] stage_q [MAX_DELAY];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < MAX_DELAY; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int k = 1; k < MAX_DELAY; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  // Tap k selects stage k-1; any request beyond MAX_DELAY lands on the last stage.
  always_comb begin
    dout = din;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if ((32'(delay_sel) == k) || (k == MAX_DELAY && 32'(delay_sel) > MAX_DELAY))
        dout = stage_q[k-1];
    end
  end

endmodule

// File: rtl/config_pipe_core.sv
// Generic tile core: bank of NUM_REGS byte-writable config registers with a
// registered read-back path, plus a 16b lane and a 1b lane passed through a
// programmable delay line (REG0[3:0]) and an output gate (REG1[0]).
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low
//   cfg          : config bus (slave side)
//   data_in_16b  : wide lane input
//   data_in_1b   : bit lane input
//   data_out_16b : delayed, gated wide lane
//   data_out_1b  : delayed, gated bit lane
module config_pipe_core
  import config_pipe_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int CONFIG_ADDR_WIDTH = 8,
  parameter int CONFIG_DATA_WIDTH = 32,
  parameter int NUM_REGS          = 4,
  parameter int MAX_DELAY         = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  config_pipe_core_if.slave     cfg,
  input  logic [DATA_WIDTH-1:0] data_in_16b,
  input  logic                  data_in_1b,
  output logic [DATA_WIDTH-1:0] data_out_16b,
  output logic                  data_out_1b
);

  localparam int NUM_BYTES = CONFIG_DATA_WIDTH / 8;

  logic [CONFIG_DATA_WIDTH-1:0] cfg_q [NUM_REGS];
  logic [CONFIG_DATA_WIDTH-1:0] rd_word;
  logic [CONFIG_DATA_WIDTH-1:0] rd_data_p1;
  logic                         rd_vld_p1;
  logic [DELAY_W-1:0]           delay_sel;
  logic                         out_en;
  logic [DATA_WIDTH-1:0]        lane16_dly;
  logic                         lane1_dly;

  // Unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(cfg.config_config_addr) == i) rd_word = cfg_q[i];
    end
  end

  // Stage p1: register writes and read-back capture. rd_word is sampled from
  // the pre-write contents, so a same-address read/write returns the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) cfg_q[i] <= '0;
      rd_data_p1 <= '0;
      rd_vld_p1  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cfg.config_write && 32'(cfg.config_config_addr) == i) begin
          for (int b = 0; b < NUM_BYTES; b++) begin
            cfg_q[i][8*b +: 8] <= merge_byte(cfg_q[i][8*b +: 8],
                                             cfg.config_config_data[8*b +: 8],
                                             cfg.config_byte_en[b]);
          end
        end
      end
      rd_vld_p1 <= cfg.config_read;
      if (cfg.config_read) rd_data_p1 <= rd_word;
    end
  end

  assign cfg.read_config_data  = rd_data_p1;
  assign cfg.read_config_valid = rd_vld_p1;

  assign delay_sel = cfg_q[REG_DELAY][DELAY_LSB +: DELAY_W];
  assign out_en    = cfg_q[REG_CTRL][OUT_EN_BIT];

  config_pipe_delay_line #(
    .WIDTH     (DATA_WIDTH),
    .MAX_DELAY (MAX_DELAY)
  ) u_lane16 (
    .clk       (clk),
    .reset     (reset),
    .din       (data_in_16b),
    .delay_sel (delay_sel),
    .dout      (lane16_dly)
  );

  config_pipe_delay_line #(
    .WIDTH     (1),
    .MAX_DELAY (MAX_DELAY)
  ) u_lane1 (
    .clk       (clk),
    .reset     (reset),
    .din       (data_in_1b),
    .delay_sel (delay_sel),
    .dout      (lane1_dly)
  );

  // Gate sits after the delay line so clearing OUT_EN blanks the outputs
  // on the same cycle the register changes.
  assign data_out_16b = out_en ? lane16_dly : '0;
  assign data_out_1b  = out_en & lane1_dly;

endmodule

// File: tb/tb_config_pipe_core.sv
module tb_config_pipe_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in_16b;
  logic        data_in_1b;
  logic [15:0] data_out_16b;
  logic        data_out_1b;

  config_pipe_core_if #(.CONFIG_ADDR_WIDTH(8), .CONFIG_DATA_WIDTH(32)) cfg_bus ();

  config_pipe_core #(
    .DATA_WIDTH(16), .CONFIG_ADDR_WIDTH(8), .CONFIG_DATA_WIDTH(32),
    .NUM_REGS(4), .MAX_DELAY(7)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg          (cfg_bus),
    .data_in_16b  (data_in_16b),
    .data_in_1b   (data_in_1b),
    .data_out_16b (data_out_16b),
    .data_out_1b  (data_out_1b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Registers as a plain array; lane inputs logged by sample index. The
  // expected output with delay d>0 is the sample taken d edges ago, or 0 if
  // that sample predates the latest reset.
  logic [31:0] mregs [4] = '{default: 32'h0};
  logic        exp_vld   = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic [15:0] log16 [4096];
  logic        log1  [4096];
  int          cyc = 0;
  int          valid_from = 0;
  int          m_a;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) mregs[i] = 32'h0;
      exp_vld   = 1'b0;
      exp_rdata = 32'h0;
      cyc = cyc + 1;
      valid_from = cyc;
    end else begin
      log16[cyc % 4096] = data_in_16b;
      log1[cyc % 4096]  = data_in_1b;
      cyc = cyc + 1;
      m_a = int'(cfg_bus.config_config_addr);
      exp_vld = cfg_bus.config_read;
      if (cfg_bus.config_read) exp_rdata = (m_a < 4) ? mregs[m_a] : 32'h0;
      if (cfg_bus.config_write && m_a < 4)
        for (int b = 0; b < 4; b++)
          if (cfg_bus.config_byte_en[b]) mregs[m_a][8*b +: 8] = cfg_bus.config_config_data[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    int d, idx;
    logic [15:0] e16;
    logic        e1;
    if (chk_on) begin
      d = int'(mregs[0][3:0]);
      if (d > 7) d = 7;
      if (!mregs[1][0]) begin
        e16 = 16'h0; e1 = 1'b0;
      end else if (d == 0) begin
        e16 = data_in_16b; e1 = data_in_1b;
      end else begin
        idx = cyc - d;
        e16 = (idx >= valid_from) ? log16[idx % 4096] : 16'h0;
        e1  = (idx >= valid_from) ? log1[idx % 4096]  : 1'b0;
      end
      chk("model_vld",   32'(cfg_bus.read_config_valid), 32'(exp_vld));
      chk("model_rdata", cfg_bus.read_config_data, exp_rdata);
      chk("model_out16", 32'(data_out_16b), 32'(e16));
      chk("model_out1",  32'(data_out_1b), 32'(e1));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    cfg_bus.config_config_addr = a;
    cfg_bus.config_config_data = d;
    cfg_bus.config_byte_en     = be;
    cfg_bus.config_write       = 1'b1;
    step();
    cfg_bus.config_write   = 1'b0;
    cfg_bus.config_byte_en = 4'h0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
    cfg_bus.config_config_addr = a;
    cfg_bus.config_read        = 1'b1;
    step();
    cfg_bus.config_read = 1'b0;
    chk(nm, cfg_bus.read_config_data, exp);
    chk({nm, "_vld"}, 32'(cfg_bus.read_config_valid), 32'h1);
    step();
    chk({nm, "_vld_low"}, 32'(cfg_bus.read_config_valid), 32'h0);
  endtask

  logic [15:0] pat = 16'b0010_1101_1001_0110;

  initial begin
    reset = 1'b0;
    data_in_16b = 16'h0;
    data_in_1b  = 1'b0;
    cfg_bus.config_config_addr = 8'h0;
    cfg_bus.config_config_data = 32'h0;
    cfg_bus.config_byte_en     = 4'h0;
    cfg_bus.config_read        = 1'b0;
    cfg_bus.config_write       = 1'b0;
    repeat (3) step();
    chk("rst_vld",   32'(cfg_bus.read_config_valid), 32'h0);
    chk("rst_rdata", cfg_bus.read_config_data, 32'h0);
    chk("rst_out16", 32'(data_out_16b), 32'h0);
    chk("rst_out1",  32'(data_out_1b), 32'h0);
    reset  = 1'b1;
    chk_on = 1'b1;

    // OUT_EN defaults to 0
    data_in_16b = 16'hABCD; data_in_1b = 1'b1;
    step();
    chk("gate_default", 32'(data_out_16b), 32'h0);

    // byte-enabled write
    wr(8'd2, 32'h11223344, 4'b1111);
    wr(8'd2, 32'hFFFFFFFF, 4'b0010);
    rd(8'd2, 32'h1122FF44, "byte_en_rd");

    // out-of-range
    wr(8'h05, 32'hDEADBEEF, 4'b1111);
    rd(8'h05, 32'h0, "oor_rd");
    rd(8'd0, 32'h0, "reg0_keep");
    rd(8'd1, 32'h0, "reg1_keep");
    rd(8'd2, 32'h1122FF44, "reg2_keep");
    rd(8'd3, 32'h0, "reg3_keep");

    // read/write collision
    wr(8'd3, 32'h5, 4'b1111);
    cfg_bus.config_config_addr = 8'd3;
    cfg_bus.config_config_data = 32'h9;
    cfg_bus.config_byte_en     = 4'b1111;
    cfg_bus.config_read        = 1'b1;
    cfg_bus.config_write       = 1'b1;
    step();
    cfg_bus.config_read  = 1'b0;
    cfg_bus.config_write = 1'b0;
    chk("collide_old", cfg_bus.read_config_data, 32'h5);
    rd(8'd3, 32'h9, "collide_new");

    // delay 0: combinational pass-through
    wr(8'd1, 32'h1, 4'b1111);
    wr(8'd0, 32'h0, 4'b1111);
    for (int i = 0; i < 6; i++) begin
      data_in_16b = 16'h100 + 16'(i); data_in_1b = pat[i];
      #1;
      chk("d0_out16", 32'(data_out_16b), 32'(16'h100 + 16'(i)));
      step();
    end

    // delay 3
    wr(8'd0, 32'h3, 4'b0001);
    for (int i = 0; i < 12; i++) begin
      data_in_16b = 16'h200 + 16'(i); data_in_1b = pat[i];
      #1;
      if (i >= 3) begin
        chk("d3_out16", 32'(data_out_16b), 32'(16'h200 + 16'(i - 3)));
        chk("d3_out1",  32'(data_out_1b), 32'(pat[i-3]));
      end
      step();
    end

    // delay 15 saturates to 7
    wr(8'd0, 32'hF, 4'b0001);
    for (int i = 0; i < 12; i++) begin
      data_in_16b = 16'h300 + 16'(i); data_in_1b = pat[i];
      #1;
      if (i >= 7) begin
        chk("d15_out16", 32'(data_out_16b), 32'(16'h300 + 16'(i - 7)));
        chk("d15_out1",  32'(data_out_1b), 32'(pat[i-7]));
      end
      step();
    end

    // mid-stream change 3 -> 1
    wr(8'd0, 32'h3, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      data_in_16b = 16'h400 + 16'(i); data_in_1b = pat[i];
      if (i == 6) begin
        cfg_bus.config_config_addr = 8'd0;
        cfg_bus.config_config_data = 32'h1;
        cfg_bus.config_byte_en     = 4'b0001;
        cfg_bus.config_write       = 1'b1;
        #1;
        chk("chg_before", 32'(data_out_16b), 32'h403);
        step();
        cfg_bus.config_write = 1'b0;
        chk("chg_after16", 32'(data_out_16b), 32'h406);
        chk("chg_after1",  32'(data_out_1b), 32'(pat[6]));
      end else begin
        step();
      end
    end

    // clear OUT_EN
    data_in_16b = 16'h7777; data_in_1b = 1'b1;
    wr(8'd1, 32'h0, 4'b1111);
    chk("gate_off16", 32'(data_out_16b), 32'h0);
    chk("gate_off1",  32'(data_out_1b), 32'h0);

    // mid-operation reset
    wr(8'd1, 32'h1, 4'b1111);
    wr(8'd0, 32'h2, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      data_in_16b = 16'h500 + 16'(i); data_in_1b = pat[i];
      step();
    end
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_out16", 32'(data_out_16b), 32'h0);
    chk("mid_rst_vld",   32'(cfg_bus.read_config_valid), 32'h0);
    step();
    reset = 1'b1;
    chk("post_rst_out16", 32'(data_out_16b), 32'h0);
    rd(8'd0, 32'h0, "post_rst_reg0");
    wr(8'd1, 32'h1, 4'b1111);
    wr(8'd0, 32'h2, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      data_in_16b = 16'h600 + 16'(i); data_in_1b = pat[i];
      step();
    end

    chk_on = 1'b0;
    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
